// File: rtl/fp_multi_accumulator_pkg.sv
// Shared definitions for the multi-channel FP32 accumulator.
// Holds the field widths, the special-value constants, the unpacked
// operand type and the unpack helper used at pipeline entry and
// at accumulator read.
package fp_acc_pkg;

    localparam int              EXP_W         = 8;
    localparam int              MAN_W         = 23;
    localparam logic [7:0]      EXP_MAX       = 8'hFF;
    localparam logic [30:0]     FP_MAX_FINITE = 31'h7F7FFFFF;
    localparam int              ALIGN_LIMIT   = 26;

    // Operand with the hidden bit made explicit in sig.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig;
    } fp_unpacked_t;

    // Exponent 0 covers both zero and denormal inputs.
    // Both are flushed to a zero significand.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] word);
        fp_unpacked_t u;
        u.sign = word[31];
        u.exp  = word[30:23];
        if (word[30:23] == 8'h00) begin
            u.sig = '0;
        end else begin
            u.sig = {1'b1, word[22:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/fp_multi_accumulator_if.sv
// Bundle of the increment, read-and-clear and result signals of the
// accumulator.
//   master: drives in_valid/in_ch/in_data and clr_valid/clr_ch.
//           Observes ready, result, flags and busy.
//   slave : the accumulator side.
interface fp_acc_if #(parameter int N_CH = 4) ();
    localparam int CH_W = $clog2(N_CH);

    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic [31:0]     in_data;
    logic            clr_valid;
    logic            clr_ready;
    logic [CH_W-1:0] clr_ch;
    logic            out_valid;
    logic [CH_W-1:0] out_ch;
    logic [31:0]     out_data;
    logic [N_CH-1:0] exc_flags;
    logic            busy;

    modport master (
        output in_valid, in_ch, in_data, clr_valid, clr_ch,
        input  in_ready, clr_ready, out_valid, out_ch, out_data, exc_flags, busy
    );

    modport slave (
        input  in_valid, in_ch, in_data, clr_valid, clr_ch,
        output in_ready, clr_ready, out_valid, out_ch, out_data, exc_flags, busy
    );
endinterface

// File: rtl/fp_multi_accumulator_lzc24.sv
// Combinational leading-zero counter for a 24-bit significand.
//   value : significand to inspect
//   count : number of zeros above the highest set bit (24 when value is 0)
module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scan upward so that the highest set bit writes last and wins.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            count = value[i] ? 5'(23 - i) : count;
        end
    end

endmodule

// File: rtl/fp_multi_accumulator.sv
// N_CH-channel FP32 accumulator with a 2-stage align/add pipeline.
// The design also supports read-and-clear and keeps sticky per-channel
// exception flags.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : fp_acc_if slave
//                - increment handshake
//                - clear handshake
//                - out_valid/out_ch/out_data result pulse
//                - exc_flags, busy
module fp_multi_accumulator
    import fp_acc_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic     clk,
    input  logic     reset,
    fp_acc_if.slave  bus
);
    localparam int CH_W = $clog2(N_CH);

    logic [31:0]     acc_r [N_CH];
    logic [N_CH-1:0] exc_flags_r;
    logic            out_valid_r;
    logic [CH_W-1:0] out_ch_r;
    logic [31:0]     out_data_r;

    logic            s1_valid_r;
    logic [CH_W-1:0] s1_ch_r;
    fp_unpacked_t    s1_op_r;

    logic            s2_valid_r;
    logic [CH_W-1:0] s2_ch_r;
    logic            s2_sign_r;
    logic            s2_sub_r;
    logic [7:0]      s2_exp_r;
    logic [23:0]     s2_big_r;
    logic [23:0]     s2_small_r;

    logic            in_ready_s;
    logic            clr_ready_s;
    logic            in_fire_s;
    logic            clr_fire_s;
    logic            in_special_s;

    fp_unpacked_t    acc_op_s;
    fp_unpacked_t    big_s;
    fp_unpacked_t    small_s;
    logic [7:0]      exp_diff_s;
    logic [23:0]     aligned_s;

    logic [24:0]        sum_s;
    logic [23:0]        diff_s;
    logic [4:0]         lz_s;
    logic               res_zero_s;
    logic signed [9:0]  res_exp_s;
    logic [22:0]        res_man_s;
    logic [31:0]        s2_result_s;
    logic               s2_ovf_s;

    // Handshake readiness.
    // - An increment must not enter behind a same-channel op still in S1.
    // - An increment must not enter alongside a same-channel clear.
    // - A clear waits until no in-flight op targets its channel.
    always_comb begin
        in_ready_s  = 1'b1;
        clr_ready_s = 1'b1;
        if (s1_valid_r && (s1_ch_r == bus.in_ch)) begin
            in_ready_s = 1'b0;
        end else if (bus.clr_valid && (bus.clr_ch == bus.in_ch)) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
        if ((s1_valid_r && (s1_ch_r == bus.clr_ch)) ||
            (s2_valid_r && (s2_ch_r == bus.clr_ch))) begin
            clr_ready_s = 1'b0;
        end else begin
            clr_ready_s = 1'b1;
        end
    end

    assign in_fire_s    = bus.in_valid && in_ready_s;
    assign clr_fire_s   = bus.clr_valid && clr_ready_s;
    assign in_special_s = (bus.in_data[30:23] == EXP_MAX);

    // S1: order the operands by magnitude.
    // Then align the smaller one, truncating the bits shifted out.
    always_comb begin
        acc_op_s = fp_unpack(acc_r[s1_ch_r]);
        if ({acc_op_s.exp, acc_op_s.sig} >= {s1_op_r.exp, s1_op_r.sig}) begin
            big_s   = acc_op_s;
            small_s = s1_op_r;
        end else begin
            big_s   = s1_op_r;
            small_s = acc_op_s;
        end
        exp_diff_s = big_s.exp - small_s.exp;
        if (exp_diff_s >= 8'(ALIGN_LIMIT)) begin
            aligned_s = 24'h000000;
        end else begin
            aligned_s = small_s.sig >> exp_diff_s;
        end
    end

    assign sum_s  = {1'b0, s2_big_r} + {1'b0, s2_small_r};
    assign diff_s = s2_big_r - s2_small_r;

    fp_lzc24 u_lzc (
        .value (diff_s),
        .count (lz_s)
    );

    // S2: add or subtract the significands, then normalize and pack.
    // Out-of-range results saturate or flush.
    always_comb begin
        res_zero_s  = 1'b0;
        res_exp_s   = 10'sd0;
        res_man_s   = 23'h0;
        s2_ovf_s    = 1'b0;
        s2_result_s = 32'h0;
        if (s2_sub_r) begin
            if (diff_s == 24'h000000) begin
                res_zero_s = 1'b1;
            end else begin
                res_exp_s = $signed({2'b00, s2_exp_r}) - $signed({5'b00000, lz_s});
                res_man_s = 23'(diff_s << lz_s);
            end
        end else if (sum_s[24]) begin
            res_exp_s = $signed({2'b00, s2_exp_r}) + 10'sd1;
            res_man_s = sum_s[23:1];
        end else begin
            res_exp_s = $signed({2'b00, s2_exp_r});
            res_man_s = sum_s[22:0];
        end

        if (res_zero_s) begin
            s2_result_s = 32'h0;
        end else if (res_exp_s >= 10'sd255) begin
            s2_result_s = {s2_sign_r, FP_MAX_FINITE};
            s2_ovf_s    = 1'b1;
        end else if (res_exp_s <= 10'sd0) begin
            s2_result_s = 32'h0;
        end else begin
            s2_result_s = {s2_sign_r, res_exp_s[7:0], res_man_s};
        end
    end

    // Pipeline stage registers.
    // Inf/NaN increments complete the handshake but never enter S1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_ch_r    <= '0;
            s1_op_r    <= '0;
            s2_valid_r <= 1'b0;
            s2_ch_r    <= '0;
            s2_sign_r  <= 1'b0;
            s2_sub_r   <= 1'b0;
            s2_exp_r   <= 8'h00;
            s2_big_r   <= 24'h000000;
            s2_small_r <= 24'h000000;
        end else begin
            s1_valid_r <= in_fire_s && !in_special_s;
            if (in_fire_s) begin
                s1_ch_r <= bus.in_ch;
                s1_op_r <= fp_unpack(bus.in_data);
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_ch_r    <= s1_ch_r;
                s2_sign_r  <= big_s.sign;
                s2_sub_r   <= big_s.sign ^ small_s.sign;
                s2_exp_r   <= big_s.exp;
                s2_big_r   <= big_s.sig;
                s2_small_r <= aligned_s;
            end
        end
    end

    // Accumulator write-back and sticky flags.
    // Clear and write-back never target the same channel in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                acc_r[i] <= 32'h0;
            end
            exc_flags_r <= '0;
        end else begin
            if (s2_valid_r) begin
                acc_r[s2_ch_r] <= s2_result_s;
                if (s2_ovf_s) begin
                    exc_flags_r[s2_ch_r] <= 1'b1;
                end
            end
            if (in_fire_s && in_special_s) begin
                exc_flags_r[bus.in_ch] <= 1'b1;
            end
            if (clr_fire_s) begin
                acc_r[bus.clr_ch]       <= 32'h0;
                exc_flags_r[bus.clr_ch] <= 1'b0;
            end
        end
    end

    // Read-and-clear result register; out_valid is a single-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_ch_r    <= '0;
            out_data_r  <= 32'h0;
        end else begin
            out_valid_r <= clr_fire_s;
            if (clr_fire_s) begin
                out_ch_r   <= bus.clr_ch;
                out_data_r <= acc_r[bus.clr_ch];
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.clr_ready = clr_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_data  = out_data_r;
    assign bus.exc_flags = exc_flags_r;
    assign bus.busy      = s1_valid_r | s2_valid_r;

endmodule

// File: tb/tb_fp_multi_accumulator.sv
// Self-checking bench for fp_multi_accumulator.
// Clears push their expected result into a scoreboard queue.
// A monitor pops and compares whenever out_valid is seen.
module tb_fp_multi_accumulator;
    localparam int N_CH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    fp_acc_if #(.N_CH(N_CH)) bus ();

    fp_multi_accumulator #(.N_CH(N_CH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [31:0]     m_acc [N_CH];
    logic [N_CH-1:0] m_exc;
    logic [33:0]     exp_q [$];

    // Reference FP add under the accumulator's rules.
    // The rules are: truncating alignment, 26-bit cutoff, flush and saturate.
    // The return value is {overflow, result}.
    function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, el, es, e;
        longint ma, mb, ml, ms, r;
        logic   sa, sb, sl, ss;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 64'd0 : (64'd8388608 + longint'(a[22:0]));
        mb = (eb == 0) ? 64'd0 : (64'd8388608 + longint'(b[22:0]));
        if (ea == 0) ea = 0;
        if (eb == 0) eb = 0;
        sa = a[31];
        sb = b[31];
        if ((ea > eb) || ((ea == eb) && (ma >= mb))) begin
            el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb;
        end else begin
            el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa;
        end
        if ((el - es) >= 26) ms = 0;
        else ms = ms >> (el - es);
        r = (sl != ss) ? (ml - ms) : (ml + ms);
        e = el;
        if (r == 0) return 33'h0;
        while (r >= 64'd16777216) begin r = r >> 1; e = e + 1; end
        while (r < 64'd8388608) begin r = r << 1; e = e - 1; end
        if (e >= 255) return {1'b1, sl, 31'h7F7FFFFF};
        if (e <= 0) return 33'h0;
        return {1'b0, sl, e[7:0], r[22:0]};
    endfunction

    // Random FP32 operand.
    // The value is mostly moderate and occasionally special, zero/denormal or huge.
    function automatic logic [31:0] rand_fp();
        int         k;
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        k = $urandom_range(0, 19);
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        if (k == 0) e = 8'hFF;
        else if (k == 1) e = 8'h00;
        else if (k == 2) e = 8'hFE;
        else e = 8'($urandom_range(120, 132));
        return {s, e, m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Scoreboard monitor: every out_valid pulse must match the next expectation.
    task automatic monitor();
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_unexpected: got ch %0d data %h, nothing expected", bus.out_ch, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_ch, bus.out_data} !== e) begin
                        n_fail++;
                        $display("FAIL out_data: got ch %0d data %h expected ch %0d data %h",
                                 bus.out_ch, bus.out_data, e[33:32], e[31:0]);
                    end
                end
            end
        end
    endtask

    // One clock of stimulus.
    // Handshakes are judged just before the edge, and the model follows accepted ops.
    // A fixed clear expectation overrides the model's value.
    task automatic cycle(input bit iv, input logic [1:0] ich, input logic [31:0] idata,
                         input bit cv, input logic [1:0] cch, input bit fixed,
                         input logic [31:0] want, output bit in_acc, output bit clr_acc,
                         output bit rdy);
        logic [32:0] r;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_ch     = ich;
        bus.in_data   = idata;
        bus.clr_valid = cv;
        bus.clr_ch    = cch;
        #1;
        rdy     = bus.in_ready;
        in_acc  = iv && bus.in_ready;
        clr_acc = cv && bus.clr_ready;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.clr_valid = 1'b0;
        if (clr_acc) begin
            exp_q.push_back({cch, fixed ? want : m_acc[cch]});
            m_acc[cch] = 32'h0;
            m_exc[cch] = 1'b0;
        end
        if (in_acc) begin
            if (idata[30:23] == 8'hFF) begin
                m_exc[ich] = 1'b1;
            end else begin
                r = model_add(m_acc[ich], idata);
                m_acc[ich] = r[31:0];
                if (r[32]) m_exc[ich] = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        bit ia, ca, rd;
        for (int i = 0; i < n; i++) cycle(0, 2'd0, 32'h0, 0, 2'd0, 0, 32'h0, ia, ca, rd);
    endtask

    task automatic inc(input logic [1:0] ch, input logic [31:0] d);
        bit ia, ca, rd;
        int tries;
        tries = 0;
        do begin
            cycle(1, ch, d, 0, 2'd0, 0, 32'h0, ia, ca, rd);
            tries++;
        end while (!ia && tries < 20);
        if (!ia) begin
            n_checks++;
            n_fail++;
            $display("FAIL inc_timeout: ch %0d never accepted, required acceptance", ch);
        end
    endtask

    task automatic clear(input logic [1:0] ch, input bit fixed, input logic [31:0] want);
        bit ia, ca, rd;
        int tries;
        tries = 0;
        do begin
            cycle(0, 2'd0, 32'h0, 1, ch, fixed, want, ia, ca, rd);
            tries++;
        end while (!ca && tries < 20);
        if (!ca) begin
            n_checks++;
            n_fail++;
            $display("FAIL clr_timeout: ch %0d never accepted, required acceptance", ch);
        end
    endtask

    initial begin
        bit          ia, ca, rd;
        logic [3:0]  want_rdy;
        logic [1:0]  ich, cch;
        bit          iv, cv;

        bus.in_valid  = 1'b0;
        bus.in_ch     = 2'd0;
        bus.in_data   = 32'h0;
        bus.clr_valid = 1'b0;
        bus.clr_ch    = 2'd0;
        for (int i = 0; i < N_CH; i++) m_acc[i] = 32'h0;
        m_exc = '0;
        fork
            monitor();
        join_none

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_ch", 32'(bus.out_ch), 32'h0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_exc", 32'(bus.exc_flags), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'h1);
        check("idle_clr_ready", 32'(bus.clr_ready), 32'h1);

        // 1.0 + 2.0 on ch0, then a second clear returns zero
        inc(2'd0, 32'h3F800000);
        inc(2'd0, 32'h40000000);
        idle(2);
        check("exc_after_add", 32'(bus.exc_flags), 32'h0);
        clear(2'd0, 1, 32'h40400000);
        clear(2'd0, 1, 32'h00000000);

        // Exact cancellation, then 1.0 - 0.5 on ch1
        inc(2'd1, 32'h40400000);
        inc(2'd1, 32'hC0400000);
        clear(2'd1, 1, 32'h00000000);
        inc(2'd1, 32'h3F800000);
        inc(2'd1, 32'hBF000000);
        clear(2'd1, 1, 32'h3F000000);

        // Same-channel throughput: in_ready toggles
        idle(3);
        want_rdy = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 2'd2, 32'h3F800000, 0, 2'd0, 0, 32'h0, ia, ca, rd);
            check($sformatf("rdy_same_%0d", i), 32'(rd), 32'(want_rdy[3-i]));
        end
        // Alternating channels: in_ready stays high
        for (int i = 0; i < 6; i++) begin
            cycle(1, (i % 2 == 0) ? 2'd3 : 2'd2, 32'h3F800000, 0, 2'd0, 0, 32'h0, ia, ca, rd);
            check($sformatf("rdy_alt_%0d", i), 32'(rd), 32'h1);
        end
        inc(2'd3, 32'h3F800000);
        inc(2'd3, 32'h3F800000);
        clear(2'd2, 1, 32'h40A00000);
        clear(2'd3, 1, 32'h40A00000);

        // Overflow saturation and sticky flag on ch0
        inc(2'd0, 32'h7F7FFFFF);
        inc(2'd0, 32'h7F7FFFFF);
        idle(3);
        check("ovf_flag_set", 32'(bus.exc_flags[0]), 32'h1);
        clear(2'd0, 1, 32'h7F7FFFFF);
        idle(1);
        check("ovf_flag_cleared", 32'(bus.exc_flags[0]), 32'h0);

        // NaN to ch1: dropped, flagged, no pipeline entry
        inc(2'd1, 32'h3F800000);
        idle(3);
        inc(2'd1, 32'h7FC00000);
        check("nan_no_busy", 32'(bus.busy), 32'h0);
        check("nan_flag", 32'(bus.exc_flags[1]), 32'h1);
        clear(2'd1, 1, 32'h3F800000);
        idle(1);
        check("nan_flag_cleared", 32'(bus.exc_flags[1]), 32'h0);

        // Small operand aligned away
        inc(2'd3, 32'h3F800000);
        inc(2'd3, 32'h30800000);
        clear(2'd3, 1, 32'h3F800000);
        // Clear and increment to the same channel in one cycle
        idle(3);
        cycle(1, 2'd3, 32'h3F800000, 1, 2'd3, 1, 32'h00000000, ia, ca, rd);
        check("same_ch_clr_acc", 32'(ca), 32'h1);
        check("same_ch_in_ready", 32'(rd), 32'h0);
        idle(3);

        // Randomized mix checked against the model
        for (int i = 0; i < 400; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            ich = 2'($urandom_range(0, 3));
            cv  = ($urandom_range(0, 5) == 0);
            cch = 2'($urandom_range(0, 3));
            cycle(iv, ich, rand_fp(), cv, cch, 0, 32'h0, ia, ca, rd);
        end
        idle(4);
        check("rand_exc_flags", 32'(bus.exc_flags), 32'(m_exc));
        for (int c = 0; c < N_CH; c++) clear(2'(c), 0, 32'h0);
        idle(3);

        // Reset while busy discards in-flight work
        inc(2'd3, 32'h3F800000);
        idle(3);
        inc(2'd2, 32'h7F800000);
        clear(2'd3, 1, 32'h3F800000);
        idle(2);
        inc(2'd0, 32'h3F800000);
        inc(2'd1, 32'h3F800000);
        check("busy_before_reset", 32'(bus.busy), 32'h1);
        check("queue_before_reset", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_out_ch", 32'(bus.out_ch), 32'h0);
        check("midrst_out_data", bus.out_data, 32'h0);
        check("midrst_exc", 32'(bus.exc_flags), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N_CH; i++) m_acc[i] = 32'h0;
        m_exc = '0;
        idle(2);
        for (int c = 0; c < N_CH; c++) clear(2'(c), 1, 32'h00000000);

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_multi_accumulator.md
Name: fp_multi_accumulator

Overview:
- N_CH-channel IEEE-754 single-precision accumulator for per-neuron or per-synapse-group membrane integration inside the neuron tile.
- Accepts signed FP32 increments over a valid/ready handshake into a 2-stage align/add pipeline.
- Keeps one accumulator per channel.
- Supports read-and-clear of any channel, with sticky per-channel exception flags.

Parameters:
- N_CH, 4, number of independent accumulator channels (>=2).
- CH_W, $clog2(N_CH), channel index width (derived, not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  increment request
- in_ready  out  1  increment accepted when in_valid & in_ready at posedge
- in_ch  in  CH_W  target channel
- in_data  in  32  signed FP32 increment
- clr_valid  in  1  read-and-clear request
- clr_ready  out  1  clear accepted when clr_valid & clr_ready at posedge
- clr_ch  in  CH_W  channel to read and clear
- out_valid  out  1  one-cycle pulse, out_data valid
- out_ch  out  CH_W  channel of out_data
- out_data  out  32  accumulator value before clear
- exc_flags  out  N_CH  sticky exception per channel
- busy  out  1  S1 or S2 valid

Behaviour:
- Reset: all accumulators +0 (0x00000000); S1/S2 invalid; out_valid=0, out_ch=0, out_data=0, exc_flags=0, busy=0. Reset mid-operation discards in-flight ops with no write-back.
- Pipeline timing:
  - Accept edge loads S1.
  - Next cycle, S1 reads acc[ch], unpacks, compares, aligns, and loads S2.
  - Next cycle, S2 adds, normalizes, and writes acc[ch] at the end of that cycle.
  - An increment accepted at edge t is visible at edge t+2.
- in_ready = 0 when any of these hold; otherwise 1:
  - S1 is valid and S1.ch == in_ch.
  - clr_valid && clr_ch == in_ch.
- Resulting throughput: same channel 1 per 2 cycles; different channels 1 per cycle.
- clr_ready = 0 when S1 or S2 holds clr_ch; otherwise 1.
- On clear accept:
  - out_data <= acc[clr_ch], out_ch <= clr_ch, out_valid <= 1 for one cycle.
  - acc[clr_ch] <= +0; exc_flags[clr_ch] <= 0.
  - A clear and an increment may be accepted in the same cycle only for different channels.
- Operand rules:
  - Exponent 0 is treated as ±0; denormals are flushed.
  - Exponent 0xFF (Inf/NaN) input: dropped with no S1 entry, but in_ready handshake still completes; sets exc_flags[in_ch].
- Arithmetic:
  - Larger magnitude is selected by {exp, mantissa}; the smaller hidden-bit significand is right-shifted by the exponent difference.
  - Difference >= 26 makes the smaller operand 0.
  - Effective add or subtract follows the signs; result sign is the sign of the larger magnitude.
  - Rounding is truncation (round-toward-zero); no guard/sticky bits.
  - Carry-out: shift right 1, exponent +1.
  - Cancellation: left-normalize by leading-zero count, exponent minus count.
  - Exact zero gives +0.
- Overflow: result exponent >= 255 saturates to ±0x7F7FFFFF and sets exc_flags[ch].
- Underflow: result exponent <= 0 flushes to +0 with no flag.
- exc_flags bits are sticky until that channel is cleared or reset.

Decomposition:
- Package fp_acc_pkg holds:
  - EXP_W=8, MAN_W=23, EXP_MAX=8'hFF
  - FP_MAX_FINITE=31'h7F7FFFFF
  - ALIGN_LIMIT=26
  - an unpacked-operand struct typedef {sign, exp, sig[23:0]}
- One sub-module: fp_lzc24, a combinational 24-bit leading-zero counter used in S2 normalization.

Test Plan:
- ch0 gets 0x3F800000 (1.0) then 0x40000000 (2.0), then clear ch0 -> out_data=0x40400000 (3.0), out_ch=0, exc_flags=0; a second clear returns 0x00000000.
- ch1 gets 0x40400000 (3.0) then 0xC0400000 (-3.0) -> clear gives 0x00000000; ch1 gets 0x3F800000 then 0xBF000000 -> clear gives 0x3F000000 (0.5).
- in_valid held with alternating ch2/ch2 -> in_ready toggles 1,0,1,0; with ch2/ch3 -> in_ready stays 1. Five 1.0 increments per channel -> each clear gives 0x40A00000.
- ch0 gets 0x7F7FFFFF twice -> clear gives 0x7F7FFFFF, exc_flags[0]=1 before clear and 0 after; 0x7FC00000 (NaN) to ch1 -> acc unchanged, exc_flags[1]=1.
- 0x3F800000 + 0x30800000 (2^-30) -> 0x3F800000 (aligned away); clr_valid and in_valid to ch3 in the same cycle -> clear accepted, in_ready=0.
- Issue increments, then assert reset while busy=1 -> all outputs 0; subsequent clears of every channel return 0x00000000.
